stop_watch_unit: RTL
====================

# stop_watch_unit

Stopwatch datapath and control that feeds the clock's mode controller. It counts minutes and seconds (MM:SS, 00:00–59:59) from a prescaled system clock and is started, paused and cleared by the shared front-panel buttons while the controller holds it enabled. It drives the stopwatch value and the stop-watch acknowledge flag consumed by the mode FSM. That FSM only advances past the stopwatch mode when this block acknowledges.

## Interface
- TICK_DIV, default 1000: clk cycles per stopwatch second; legal range ≥2; prescaler width = clog2(TICK_DIV).
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- stop_watch_en  input  1  high while the mode FSM is in stopwatch mode; gates button inputs.
- inc_button  input  1  single-cycle, debounced pulse; start/pause toggle.
- clr_button  input  1  single-cycle, debounced pulse; clear while paused.
- stop_watch_minutes  output  6  registered minutes, 0–59.
- stop_watch_seconds  output  6  registered seconds, 0–59.
- stop_watch_ack_flag  output  1  high when the stopwatch is not running (IDLE or PAUSED).
- running  output  1  high in RUNNING.
- overflow  output  1  one-cycle pulse on wrap from 59:59 to 00:00.

## Operation
- States: IDLE (count 00:00, prescaler 0), RUNNING, PAUSED.
- Buttons are sampled only when stop_watch_en=1. With en=0 both buttons are ignored, the state is held, and counting continues if in RUNNING.
- IDLE + inc → RUNNING; prescaler starts at 0.
- RUNNING + inc → PAUSED. clr is ignored in RUNNING.
- PAUSED + inc → RUNNING; the prescaler resumes from its held partial value.
- PAUSED + clr → IDLE; minutes, seconds and prescaler are zeroed.
- PAUSED with inc and clr in the same cycle: clr wins → IDLE.
- IDLE + clr: no effect.
- Prescaler advances only in RUNNING. When it equals TICK_DIV-1 it returns to 0 and a tick is taken.
- On tick:
  - seconds+1.
  - At seconds=59: seconds→0, minutes+1.
  - At 59:59: both fields→0 and overflow=1 for that cycle; counting continues.
- A tick and an inc in the same RUNNING cycle: the tick increment is applied and the state goes to PAUSED on the same edge.
- Counters never exceed 59. Arithmetic is 6-bit unsigned with explicit compare-to-59; there is no modulo-64 wrap.
- stop_watch_ack_flag = (state != RUNNING), decoded from the state register. The mode FSM therefore cannot leave stopwatch mode while the watch runs.

## Timing
- Reset (rst=0, asynchronous): state=IDLE; minutes=0, seconds=0, prescaler=0; running=0, overflow=0, stop_watch_ack_flag=1. Reset mid-count discards the count immediately, with no clock edge required.
- State transitions happen on the clk edge that samples the button pulse. running and ack change in the cycle after that edge.
- First seconds increment: exactly TICK_DIV cycles after the edge that sampled the start pulse. Each later increment follows every TICK_DIV cycles.
- Pause/resume: the total RUNNING cycles between successive increments is always TICK_DIV. Time spent paused is not counted.
- overflow is asserted in the cycle following the wrapping edge, for exactly one cycle.
- All outputs are registered except stop_watch_ack_flag and running, which are state decodes with no input-to-output combinational path.

## Test plan
All scenarios use TICK_DIV=4.
- Reset: hold rst=0 with buttons toggling → outputs 00:00, running=0, ack=1, overflow=0; release rst, no buttons → remains 00:00.
- Start and count:
  - en=1, inc pulse at edge t → running=1 and ack=0 after t.
  - seconds=1 at edge t+4, seconds=2 at t+8.
  - After 60 ticks → 01:00.
- Pause/resume partial tick:
  - Start, pause 2 cycles later, wait 20 cycles → value unchanged.
  - Resume → next increment exactly 2 cycles after resume edge.
- Clear priority:
  - In PAUSED at 00:05, inc+clr same cycle → 00:00, IDLE, ack=1.
  - clr alone in RUNNING → ignored, counting continues.
- Wrap: run from 59:58 (two ticks) → 59:59 then 00:00 with a single-cycle overflow=1, then 00:01.
- Enable gating and async reset:
  - en=0, inc/clr pulses → no state change.
  - In RUNNING with en=0 → counting continues.
  - Assert rst mid-tick at 03:27 → immediate 00:00, IDLE.

Source files
------------

// File: rtl/stop_watch_unit_if.sv
// stop_watch_unit_if
//   Bundles the signals exchanged between the clock's mode controller and
//   the stopwatch unit.
//   master : mode controller side (drives enable and button pulses,
//            observes the stopwatch value and status)
//   slave  : stopwatch unit side
//   Signals:
//     stop_watch_en        enable, high while in stopwatch mode
//     inc_button           start/pause toggle pulse (single cycle)
//     clr_button           clear pulse (single cycle), honoured only when paused
//     stop_watch_minutes   minutes 0-59
//     stop_watch_seconds   seconds 0-59
//     stop_watch_ack_flag  high when the stopwatch is not running
//     running              high while counting
//     overflow             one-cycle pulse on wrap 59:59 -> 00:00
interface stop_watch_unit_if;
  logic       stop_watch_en;
  logic       inc_button;
  logic       clr_button;
  logic [5:0] stop_watch_minutes;
  logic [5:0] stop_watch_seconds;
  logic       stop_watch_ack_flag;
  logic       running;
  logic       overflow;

  modport master (
    output stop_watch_en, inc_button, clr_button,
    input  stop_watch_minutes, stop_watch_seconds, stop_watch_ack_flag,
           running, overflow
  );

  modport slave (
    input  stop_watch_en, inc_button, clr_button,
    output stop_watch_minutes, stop_watch_seconds, stop_watch_ack_flag,
           running, overflow
  );
endinterface

// File: rtl/stop_watch_unit.sv
// stop_watch_unit
//   MM:SS stopwatch (00:00 to 59:59) with an IDLE/RUNNING/PAUSED control FSM.
//   A prescaler divides clk by TICK_DIV to form one-second ticks; it only
//   advances while running, so a partial second survives a pause.
//   Ports:
//     clk  system clock, rising edge
//     rst  asynchronous, active-low reset
//     bus  stop_watch_unit_if.slave (enable, buttons, value and status)
module stop_watch_unit #(
  parameter int TICK_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst,
  stop_watch_unit_if.slave  bus
);

  localparam int               PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED} state_t;

  state_t           state;
  logic [PRE_W-1:0] prescaler;
  logic [5:0]       minutes;
  logic [5:0]       seconds;
  logic             overflow;

  logic inc_req;
  logic clr_req;
  logic tick;
  logic at_max;

  // Next value of a 0-59 field; anything at or above 59 folds back to 0 so
  // the field can never leave its legal range.
  function automatic logic [5:0] next_sixty(input logic [5:0] v);
    return (v >= 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  // Buttons only count while the mode controller has us selected.
  assign inc_req = bus.stop_watch_en & bus.inc_button;
  assign clr_req = bus.stop_watch_en & bus.clr_button;
  assign tick    = (state == RUNNING) && (prescaler == PRE_MAX);
  assign at_max  = (minutes == 6'd59) && (seconds == 6'd59);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      prescaler <= '0;
      minutes   <= '0;
      seconds   <= '0;
      overflow  <= 1'b0;
    end else begin
      overflow <= 1'b0;
      case (state)
        IDLE: begin
          if (inc_req) state <= RUNNING;
        end
        RUNNING: begin
          // The tick is applied even when a pause is sampled on the same edge.
          if (tick) begin
            prescaler <= '0;
            seconds   <= next_sixty(seconds);
            if (seconds >= 6'd59) minutes <= next_sixty(minutes);
            overflow  <= at_max;
          end else begin
            prescaler <= prescaler + PRE_W'(1);
          end
          if (inc_req) state <= PAUSED;
        end
        PAUSED: begin
          // Clear takes priority over resume.
          if (clr_req) begin
            state     <= IDLE;
            prescaler <= '0;
            minutes   <= '0;
            seconds   <= '0;
          end else if (inc_req) begin
            state <= RUNNING;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stop_watch_minutes  = minutes;
  assign bus.stop_watch_seconds  = seconds;
  assign bus.overflow            = overflow;
  assign bus.running             = (state == RUNNING);
  assign bus.stop_watch_ack_flag = (state != RUNNING);

endmodule
